// File: rtl/input_capture_pkg.sv
// Shared codes, channel indices and FSM encoding for the input capture block.
package input_capture_pkg;

  localparam int unsigned CODE_W  = 3;
  localparam int unsigned NUM_CH  = 2;
  localparam int unsigned NUM_RAW = 5;

  // Raw input positions in the debounced level vector
  localparam int unsigned IDX_UP    = 0;
  localparam int unsigned IDX_DOWN  = 1;
  localparam int unsigned IDX_LEFT  = 2;
  localparam int unsigned IDX_RIGHT = 3;
  localparam int unsigned IDX_BTN   = 4;

  // Channel numbers: joystick slot and button slot
  localparam int unsigned CH_JOY = 0;
  localparam int unsigned CH_BTN = 1;

  localparam logic [CODE_W-1:0] JOY_NONE  = 3'd0;
  localparam logic [CODE_W-1:0] JOY_UP    = 3'd1;
  localparam logic [CODE_W-1:0] JOY_DOWN  = 3'd2;
  localparam logic [CODE_W-1:0] JOY_LEFT  = 3'd3;
  localparam logic [CODE_W-1:0] JOY_RIGHT = 3'd4;
  localparam logic [CODE_W-1:0] BTN_PRESS = 3'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } cap_state_e;

  // Priority encode the joystick: up > down > left > right
  function automatic logic [CODE_W-1:0] joy_code(input logic up, input logic down,
                                                 input logic left, input logic right);
    if (up)         return JOY_UP;
    else if (down)  return JOY_DOWN;
    else if (left)  return JOY_LEFT;
    else if (right) return JOY_RIGHT;
    else            return JOY_NONE;
  endfunction

endpackage

// File: rtl/input_capture_debouncer.sv
// Two-flop synchronizer followed by a stable-sample counter debouncer.
module input_capture_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronize the raw level into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // Accept a level change only after enough consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else if (sync2_q == level_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      level_q <= ~level_q;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign level = level_q;

endmodule

// File: rtl/input_capture.sv
// Debounces joystick/button switches and posts event codes into two memory slots.
module input_capture
  import input_capture_pkg::*;
#(
  parameter int unsigned SIZE            = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            joy_up,
  input  logic            joy_down,
  input  logic            joy_left,
  input  logic            joy_right,
  input  logic            btn,
  input  logic [SIZE-1:0] input0_read_data,
  input  logic [SIZE-1:0] input1_read_data,
  output logic [SIZE-1:0] input0_write_data,
  output logic [SIZE-1:0] input1_write_data,
  output logic            input0_write_en,
  output logic            input1_write_en,
  output logic            overrun0,
  output logic            overrun1
);

  logic [NUM_RAW-1:0] raw_c;
  logic [NUM_RAW-1:0] level;

  assign raw_c = {btn, joy_right, joy_left, joy_down, joy_up};

  for (genvar i = 0; i < NUM_RAW; i++) begin : g_deb
    input_capture_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw_c[i]),
      .level(level[i])
    );
  end

  logic [CODE_W-1:0] joy_code_c;
  logic [CODE_W-1:0] joy_prev_q;
  logic              btn_prev_q;
  logic [NUM_CH-1:0] ev_valid_c;
  logic [CODE_W-1:0] ev_code_c [NUM_CH];
  logic [NUM_CH-1:0] slot_zero_c;

  assign joy_code_c = joy_code(level[IDX_UP], level[IDX_DOWN], level[IDX_LEFT], level[IDX_RIGHT]);

  // Remember last joystick code and button level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy_prev_q <= JOY_NONE;
      btn_prev_q <= 1'b0;
    end else begin
      joy_prev_q <= joy_code_c;
      btn_prev_q <= level[IDX_BTN];
    end
  end

  // Event detection and slot-empty flags per channel
  always_comb begin
    ev_valid_c[CH_JOY]  = (joy_code_c != joy_prev_q) && (joy_code_c != JOY_NONE);
    ev_code_c[CH_JOY]   = joy_code_c;
    ev_valid_c[CH_BTN]  = level[IDX_BTN] & ~btn_prev_q;
    ev_code_c[CH_BTN]   = BTN_PRESS;
    slot_zero_c[CH_JOY] = (input0_read_data == '0);
    slot_zero_c[CH_BTN] = (input1_read_data == '0);
  end

  cap_state_e        state_q      [NUM_CH];
  cap_state_e        state_nxt    [NUM_CH];
  logic [NUM_CH-1:0] held_vld_q;
  logic [NUM_CH-1:0] held_vld_nxt;
  logic [CODE_W-1:0] held_code_q  [NUM_CH];
  logic [CODE_W-1:0] held_code_nxt[NUM_CH];
  logic [CODE_W-1:0] wr_code_nxt  [NUM_CH];
  logic [NUM_CH-1:0] ovr_nxt;
  logic [NUM_CH-1:0] wr_en_q;
  logic [SIZE-1:0]   wr_data_q    [NUM_CH];
  logic [NUM_CH-1:0] ovr_q;

  // Next-state logic for each channel's delivery FSM
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_nxt[c]     = state_q[c];
      held_vld_nxt[c]  = held_vld_q[c];
      held_code_nxt[c] = held_code_q[c];
      wr_code_nxt[c]   = '0;
      ovr_nxt[c]       = 1'b0;

      // Outside IDLE a new event replaces the one-deep held code
      if (state_q[c] != ST_IDLE && ev_valid_c[c]) begin
        held_code_nxt[c] = ev_code_c[c];
        held_vld_nxt[c]  = 1'b1;
        ovr_nxt[c]       = held_vld_q[c];
      end

      case (state_q[c])
        ST_IDLE: begin
          if (ev_valid_c[c]) begin
            if (slot_zero_c[c]) begin
              state_nxt[c]   = ST_WRITE;
              wr_code_nxt[c] = ev_code_c[c];
            end else begin
              held_code_nxt[c] = ev_code_c[c];
              held_vld_nxt[c]  = 1'b1;
              state_nxt[c]     = ST_PEND;
            end
          end
        end
        ST_PEND: begin
          if (slot_zero_c[c]) begin
            state_nxt[c]     = ST_WRITE;
            wr_code_nxt[c]   = held_code_nxt[c];
            held_vld_nxt[c]  = 1'b0;
            held_code_nxt[c] = '0;
          end
        end
        ST_WRITE: state_nxt[c] = ST_WAIT;
        ST_WAIT: begin
          if (slot_zero_c[c]) state_nxt[c] = held_vld_nxt[c] ? ST_PEND : ST_IDLE;
        end
        default: state_nxt[c] = ST_IDLE;
      endcase
    end
  end

  // State register with registered write strobe, data and overrun pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_vld_q <= '0;
      wr_en_q    <= '0;
      ovr_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= ST_IDLE;
        held_code_q[c] <= '0;
        wr_data_q[c]   <= '0;
      end
    end else begin
      held_vld_q <= held_vld_nxt;
      ovr_q      <= ovr_nxt;
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c]     <= state_nxt[c];
        held_code_q[c] <= held_code_nxt[c];
        wr_en_q[c]     <= (state_nxt[c] == ST_WRITE);
        wr_data_q[c]   <= SIZE'(wr_code_nxt[c]);
      end
    end
  end

  assign input0_write_en   = wr_en_q[CH_JOY];
  assign input1_write_en   = wr_en_q[CH_BTN];
  assign input0_write_data = wr_data_q[CH_JOY];
  assign input1_write_data = wr_data_q[CH_BTN];
  assign overrun0          = ovr_q[CH_JOY];
  assign overrun1          = ovr_q[CH_BTN];

endmodule

// File: tb/tb_input_capture.sv
// Scoreboard bench for input_capture with a behavioural event/delivery model.
module tb_input_capture;

  localparam int unsigned SIZE = 16;
  localparam int DB = 4;

  logic            clk;
  logic            rst_n;
  logic [4:0]      raw;
  logic [SIZE-1:0] slot [2];
  logic [SIZE-1:0] wd0, wd1;
  logic            wen0, wen1, ov0, ov1;

  input_capture #(.SIZE(SIZE), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst_n(rst_n),
    .joy_up(raw[0]), .joy_down(raw[1]), .joy_left(raw[2]), .joy_right(raw[3]), .btn(raw[4]),
    .input0_read_data(slot[0]), .input1_read_data(slot[1]),
    .input0_write_data(wd0), .input1_write_data(wd1),
    .input0_write_en(wen0), .input1_write_en(wen1),
    .overrun0(ov0), .overrun1(ov1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Scoreboard queues filled by the model, drained by the monitor
  int wcode [2][$];
  int wcyc  [2][$];
  int ocyc  [2][$];

  // Game-side memory controls
  bit       set_req [2];
  int       set_val [2];
  bit       auto_game = 0;
  bit       s_wen   [2];
  int       s_wd    [2];

  // Observations for directed checks
  int wr_cnt [2];
  int last_code [2];
  int last_cyc [2];
  int ovr_cnt [2];

  // Model state: switch history, debounced levels, per-channel delivery
  int lvl [5], run [5], rd1 [5], rd2 [5];
  int prev_joy, prev_btn;
  int held [2];
  bit awaiting [2];
  bit wrote_last [2];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int joy_of(input int u, input int d, input int l, input int r);
    if (u != 0) return 1;
    if (d != 0) return 2;
    if (l != 0) return 3;
    if (r != 0) return 4;
    return 0;
  endfunction

  // Reference model and game memory, evaluated on each rising edge
  always @(posedge clk) begin : model
    int code, sv, cand, sample;
    int ev [2];
    cyc = cyc + 1;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        lvl[i] = 0; run[i] = 0; rd1[i] = 0; rd2[i] = 0;
      end
      prev_joy = 0; prev_btn = 0;
      for (int c = 0; c < 2; c++) begin
        held[c] = 0; awaiting[c] = 0; wrote_last[c] = 0;
        wcode[c].delete(); wcyc[c].delete(); ocyc[c].delete();
      end
    end else begin
      code  = joy_of(lvl[0], lvl[1], lvl[2], lvl[3]);
      ev[0] = (code != prev_joy && code != 0) ? code : 0;
      ev[1] = (lvl[4] == 1 && prev_btn == 0) ? 1 : 0;
      for (int c = 0; c < 2; c++) begin
        sv = int'(slot[c]);
        if (ev[c] != 0 && held[c] != 0) ocyc[c].push_back(cyc);
        if (wrote_last[c]) begin
          wrote_last[c] = 0;
          awaiting[c] = 1;
          if (ev[c] != 0) held[c] = ev[c];
        end else if (awaiting[c]) begin
          if (ev[c] != 0) held[c] = ev[c];
          if (sv == 0) awaiting[c] = 0;
        end else begin
          cand = (ev[c] != 0) ? ev[c] : held[c];
          if (cand != 0 && sv == 0) begin
            wcode[c].push_back(cand);
            wcyc[c].push_back(cyc);
            held[c] = 0;
            wrote_last[c] = 1;
          end else if (ev[c] != 0) begin
            held[c] = ev[c];
          end
        end
      end
      prev_joy = code;
      prev_btn = lvl[4];
      for (int i = 0; i < 5; i++) begin
        sample = rd2[i];
        if (sample != lvl[i]) begin
          run[i]++;
          if (run[i] == DB) begin
            lvl[i] = sample;
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
        rd2[i] = rd1[i];
        rd1[i] = int'(raw[i]);
      end
    end
    // Game memory: game writes win over a same-cycle capture write
    for (int c = 0; c < 2; c++) begin
      if (set_req[c]) slot[c] <= SIZE'(set_val[c]);
      else if (auto_game && slot[c] != '0 && $urandom_range(0, 3) == 0) slot[c] <= '0;
      else if (s_wen[c]) slot[c] <= SIZE'(s_wd[c]);
    end
  end

  // Monitor: pop and compare whenever the DUT presents a write or overrun
  always @(negedge clk) begin : monitor
    bit we [2];
    bit ov [2];
    int wd [2];
    int ec, ey;
    bit eo;
    we[0] = wen0; we[1] = wen1;
    ov[0] = ov0;  ov[1] = ov1;
    wd[0] = int'(wd0); wd[1] = int'(wd1);
    for (int c = 0; c < 2; c++) begin
      s_wen[c] = we[c];
      s_wd[c]  = wd[c];
      if (we[c]) begin
        wr_cnt[c]++;
        last_code[c] = wd[c];
        last_cyc[c]  = cyc;
        if (wcode[c].size() == 0) begin
          chk($sformatf("ch%0d unexpected write data", c), wd[c], -1);
        end else begin
          ec = wcode[c].pop_front();
          ey = wcyc[c].pop_front();
          chk($sformatf("ch%0d write data", c), wd[c], ec);
          chk($sformatf("ch%0d write cycle", c), cyc, ey);
        end
      end else begin
        chk($sformatf("ch%0d data while idle", c), wd[c], 0);
        if (wcode[c].size() != 0 && wcyc[c][0] <= cyc) begin
          ec = wcode[c].pop_front();
          ey = wcyc[c].pop_front();
          chk($sformatf("ch%0d missing write", c), 0, ec);
        end
      end
      eo = 1'b0;
      if (ocyc[c].size() != 0 && ocyc[c][0] == cyc) begin
        eo = 1'b1;
        void'(ocyc[c].pop_front());
      end
      if (ov[c]) ovr_cnt[c]++;
      chk($sformatf("ch%0d overrun", c), int'(ov[c]), int'(eo));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Game writes a value into a slot at the next rising edge; returns that edge's number
  task automatic set_slot(input int c, input int v, output int at_cyc);
    set_req[c] = 1'b1;
    set_val[c] = v;
    at_cyc = cyc + 1;
    @(negedge clk);
    set_req[c] = 1'b0;
  endtask

  initial begin : stim
    int t0, w, o, clr;
    rst_n = 1'b0;
    raw = '0;
    slot[0] = '0; slot[1] = '0;
    for (int c = 0; c < 2; c++) begin
      set_req[c] = 0; set_val[c] = 0; wr_cnt[c] = 0; ovr_cnt[c] = 0;
      last_code[c] = 0; last_cyc[c] = 0;
    end
    cycles(3);
    chk("reset outputs", int'({wen0, wen1, ov0, ov1, |wd0, |wd1}), 0);
    rst_n = 1'b1;
    cycles(2);

    // joy_up held 10 cycles into an empty slot
    t0 = cyc; w = wr_cnt[0];
    raw[0] = 1'b1; cycles(10); raw[0] = 1'b0; cycles(15);
    chk("up write count", wr_cnt[0] - w, 1);
    chk("up write code", last_code[0], 1);
    chk("up latency", last_cyc[0] - t0, 2 + DB + 1);
    set_slot(0, 0, clr); cycles(3);

    // short btn glitch is filtered out
    w = wr_cnt[1];
    raw[4] = 1'b1; cycles(2); raw[4] = 1'b0; cycles(15);
    chk("glitch no write", wr_cnt[1] - w, 0);

    // left+right together, then left released after consumption
    w = wr_cnt[0];
    raw[2] = 1'b1; raw[3] = 1'b1; cycles(12);
    chk("left+right code", last_code[0], 3);
    chk("left+right count", wr_cnt[0] - w, 1);
    set_slot(0, 0, clr);
    raw[2] = 1'b0; cycles(12);
    chk("right code", last_code[0], 4);
    chk("right count", wr_cnt[0] - w, 2);
    raw[3] = 1'b0; cycles(12);
    chk("release no event", wr_cnt[0] - w, 2);
    set_slot(0, 0, clr); cycles(3);

    // button press held off by an occupied slot
    set_slot(1, 5, clr);
    w = wr_cnt[1];
    raw[4] = 1'b1; cycles(10); raw[4] = 1'b0; cycles(10);
    chk("occupied no write", wr_cnt[1] - w, 0);
    set_slot(1, 0, clr); cycles(3);
    chk("pending delivered count", wr_cnt[1] - w, 1);
    chk("pending delivered code", last_code[1], 1);
    chk("pending delivered cycle", last_cyc[1] - clr, 1);

    // three presses while waiting for consumption
    o = ovr_cnt[1]; w = wr_cnt[1];
    for (int k = 0; k < 3; k++) begin
      raw[4] = 1'b1; cycles(8); raw[4] = 1'b0; cycles(8);
    end
    chk("overrun count", ovr_cnt[1] - o, 2);
    chk("no write while waiting", wr_cnt[1] - w, 0);
    set_slot(1, 0, clr); cycles(4);
    chk("latest delivered count", wr_cnt[1] - w, 1);
    chk("latest delivered code", last_code[1], 1);
    set_slot(1, 0, clr); cycles(5);
    chk("single delivery", wr_cnt[1] - w, 1);

    // reset while an event is pending
    set_slot(0, 7, clr);
    raw[0] = 1'b1; cycles(9);
    #2 rst_n = 1'b0;
    #1 chk("mid reset outputs", int'({wen0, wen1, ov0, ov1, |wd0, |wd1}), 0);
    raw[0] = 1'b0;
    cycles(2);
    set_slot(0, 0, clr);
    #2 rst_n = 1'b1;
    w = wr_cnt[0];
    cycles(15);
    chk("no write after reset", wr_cnt[0] - w, 0);

    // randomized switch activity with an automatic game consumer
    auto_game = 1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        int i;
        i = $urandom_range(0, 4);
        raw[i] = ~raw[i];
      end
      @(negedge clk);
    end
    raw = '0;
    cycles(60);
    chk("joy queue drained", wcode[0].size(), 0);
    chk("btn queue drained", wcode[1].size(), 0);
    chk("random writes seen", int'(wr_cnt[0] > 20 && wr_cnt[1] > 10), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/input_capture.md
INPUT_CAPTURE -- requirements
Module: input_capture

Interface
REQ-001 SHALL have parameter SIZE, default 16: width of each memory data word.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples required to accept a level change.
REQ-003 SHALL have port clk, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have ports joy_up, joy_down, joy_left, joy_right, btn, input, 1 each: raw asynchronous active-high switch levels.
REQ-006 SHALL have ports input0_read_data, input1_read_data, input, SIZE each: current contents of the joystick and button memory slots.
REQ-007 SHALL have ports input0_write_data, input1_write_data, output, SIZE each: event code to write to the joystick and button slots.
REQ-008 SHALL have ports input0_write_en, input1_write_en, output, 1 each: one-cycle write strobes to the joystick and button slots.
REQ-009 SHALL have ports overrun0, overrun1, output, 1 each: one-cycle pulse when a pending event is overwritten.

Function
REQ-010 SHALL pass each raw input through a 2-flop synchronizer before use.
REQ-011 SHALL debounce each synchronized input: per-input counter increments while sample differs from the debounced level and clears when it matches; the debounced level toggles and the counter clears when the count reaches DEBOUNCE_CYCLES-1 with a differing sample.
REQ-012 SHALL form joystick code with priority up>down>left>right: up=1, down=2, left=3, right=4, none=0, zero-extended to SIZE.
REQ-013 SHALL raise a joystick event in any cycle where the code changes to a nonzero value; a change to 0 raises no event.
REQ-014 SHALL raise a button event, code 1, on each debounced 0->1 transition of btn.
REQ-015 SHALL run one independent FSM per channel, states IDLE, PEND, WRITE, WAIT.
REQ-016 IDLE: on event, go to WRITE if channel slot reads 0, else latch code and go to PEND.
REQ-017 PEND: go to WRITE in the first cycle the slot reads 0.
REQ-018 WRITE: assert write_en for exactly one cycle with write_data = held code; next state WAIT.
REQ-019 WAIT: remain until slot reads 0, then go to IDLE; consumption is signalled by the game writing 0 to the slot.
REQ-020 An event arriving in PEND, WRITE or WAIT SHALL replace the one-deep held code; if a held undelivered code existed, the overrun pulse SHALL fire that cycle.
REQ-021 A code held while in WRITE or WAIT SHALL be delivered by going WAIT->PEND instead of IDLE.
REQ-022 write_data SHALL be 0 whenever write_en is 0.
REQ-023 Event-to-write_en latency SHALL be 1 cycle when the slot already reads 0.
REQ-024 A capture write suppressed by a same-cycle regular memory write SHALL not be retried; the FSM proceeds per REQ-019.

Reset
REQ-025 On rst_n low, all outputs SHALL be 0, synchronizers, debounced levels (released) and counters SHALL be 0, FSMs SHALL be IDLE, held codes cleared.
REQ-026 Reset mid-operation SHALL discard pending/held events; no write SHALL occur within the first cycle after release.

Structure
REQ-027 Package input_capture_pkg SHALL hold joystick/button code constants and FSM state encoding.
REQ-028 A sub-module debouncer (synchronizer + counter, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per raw input (5 instances).

Verification (DEBOUNCE_CYCLES=4)
REQ-029 joy_up held high 10 cycles, slot reads 0 -> single input0_write_en pulse, input0_write_data=1, after 2 sync + 4 debounce + 1 cycles.
REQ-030 btn glitch high for 2 cycles -> no input1_write_en.
REQ-031 joy_left and joy_right high together -> write_data=3; then game writes 0, left released -> write_data=4.
REQ-032 button slot reads 5, btn press -> no write until slot reads 0, then write_en next cycle with data=1.
REQ-033 two btn presses while in WAIT, then third -> overrun1 pulses on the second replacement; only latest code delivered after clear.
REQ-034 rst_n asserted during PEND -> outputs 0 immediately; after release with slot 0, no write without a new event.
